udma_cfg_bridge: RTL and testbench



---
 rtl/udma_pkg.sv | 5 +
 rtl/udma_cfg_bridge_if.sv | 13 +
 rtl/udma_cfg_watchdog.sv | 18 +
 rtl/udma_cfg_bridge.sv | 106 ++++++++++
 tb/tb_udma_cfg_bridge.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/udma_pkg.sv
// udma_pkg: shared types and constants for the uDMA configuration bridge
package udma_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} udma_cfg_state_e;
  localparam logic [31:0] UDMA_CFG_ERR_DATA = 32'h0;
endpackage

// File: rtl/udma_cfg_bridge_if.sv
// udma_cfg_bridge_if: APB completer-side bus bundle for the configuration bridge
interface udma_cfg_bridge_if #(parameter int APB_ADDR_WIDTH = 12);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0] PWDATA;
  logic PWRITE;
  logic PSEL;
  logic PENABLE;
  logic [31:0] PRDATA;
  logic PREADY;
  logic PSLVERR;
  modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE, input PRDATA, PREADY, PSLVERR);
  modport slave (input PADDR, PWDATA, PWRITE, PSEL, PENABLE, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/udma_cfg_watchdog.sv
// udma_cfg_watchdog: per-transfer cycle counter that flags a hung peripheral
module udma_cfg_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + W'(1);
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/udma_cfg_bridge.sv
// udma_cfg_bridge: APB to per-peripheral register bridge with decode errors and a watchdog
module udma_cfg_bridge
  import udma_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_PERIPHS      = 9,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  udma_cfg_bridge_if.slave               apb,
  output logic [31:0]                    periph_data_o,
  output logic [REG_ADDR_WIDTH-1:0]      periph_addr_o,
  output logic                           periph_rwn_o,
  output logic [N_PERIPHS-1:0]           periph_valid_o,
  input  logic [N_PERIPHS-1:0][31:0]     periph_data_i,
  input  logic [N_PERIPHS-1:0]           periph_ready_i,
  output logic                           timeout_o,
  output logic [7:0]                     err_cnt_o
);
  localparam int ID_WIDTH = APB_ADDR_WIDTH - REG_ADDR_WIDTH - 2;
  localparam int SW = N_PERIPHS > 1 ? $clog2(N_PERIPHS) : 1;
  if ((1 << ID_WIDTH) < N_PERIPHS) begin : g_id_check
    $error("udma_cfg_bridge: ID_WIDTH too small for N_PERIPHS");
  end
  udma_cfg_state_e state_q, state_d;
  logic [ID_WIDTH-1:0] id;
  logic mapped;
  logic [SW-1:0] sel_q, sel_d;
  logic [N_PERIPHS-1:0] valid_d;
  logic [REG_ADDR_WIDTH-1:0] addr_d;
  logic [31:0] data_d, rdata_q, rdata_d;
  logic rwn_d, err_q, err_d, wd_clr, wd_en, expired;
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^apb.PADDR[1:0];
  assign id = apb.PADDR[APB_ADDR_WIDTH-1:REG_ADDR_WIDTH+2];
  assign mapped = {1'b0, id} < (ID_WIDTH + 1)'(N_PERIPHS);
  udma_cfg_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk_i, .rstn_i, .clear(wd_clr), .enable(wd_en), .expired
  );
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    valid_d   = periph_valid_o;
    addr_d    = periph_addr_o;
    data_d    = periph_data_o;
    rwn_d     = periph_rwn_o;
    err_d     = err_q;
    rdata_d   = rdata_q;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      IDLE: if (apb.PSEL && !apb.PENABLE) begin
        addr_d  = apb.PADDR[REG_ADDR_WIDTH+1:2];
        data_d  = apb.PWDATA;
        rwn_d   = !apb.PWRITE;
        sel_d   = SW'(id);
        wd_clr  = 1'b1;
        err_d   = !mapped;
        state_d = mapped ? ACCESS : RESP;
        valid_d = mapped ? N_PERIPHS'(1) << id : '0;
        rdata_d = mapped ? rdata_q : UDMA_CFG_ERR_DATA;
      end
      ACCESS: if (periph_ready_i[sel_q]) begin
        state_d = RESP;
        valid_d = '0;
        err_d   = 1'b0;
        rdata_d = periph_rwn_o ? periph_data_i[sel_q] : 32'h0;
      end else if (expired) begin
        state_d   = RESP;
        valid_d   = '0;
        err_d     = 1'b1;
        rdata_d   = UDMA_CFG_ERR_DATA;
        timeout_o = 1'b1;
      end else wd_en = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      periph_valid_o <= '0;
      periph_addr_o  <= '0;
      periph_data_o  <= '0;
      periph_rwn_o   <= 1'b0;
      err_q          <= 1'b0;
      rdata_q        <= '0;
      err_cnt_o      <= '0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      periph_valid_o <= valid_d;
      periph_addr_o  <= addr_d;
      periph_data_o  <= data_d;
      periph_rwn_o   <= rwn_d;
      err_q          <= err_d;
      rdata_q        <= rdata_d;
      if (state_q == RESP && err_q && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
    end
  assign apb.PREADY  = state_q == RESP;
  assign apb.PSLVERR = (state_q == RESP) && err_q;
  assign apb.PRDATA  = (state_q == RESP) ? rdata_q : 32'h0;
endmodule

// File: tb/tb_udma_cfg_bridge.sv
// tb_udma_cfg_bridge: directed APB transfers checked every cycle against a transfer-level model
module tb_udma_cfg_bridge;
  localparam int TO = 16;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  udma_cfg_bridge_if #(.APB_ADDR_WIDTH(12)) apb();
  logic [31:0] periph_data_o;
  logic [4:0] periph_addr_o;
  logic periph_rwn_o, timeout_o;
  logic [8:0] periph_valid_o, periph_ready_i;
  logic [8:0][31:0] periph_data_i;
  logic [7:0] err_cnt_o;
  udma_cfg_bridge #(.APB_ADDR_WIDTH(12), .N_PERIPHS(9), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rstn_i(rstn), .apb(apb),
    .periph_data_o(periph_data_o), .periph_addr_o(periph_addr_o), .periph_rwn_o(periph_rwn_o),
    .periph_valid_o(periph_valid_o), .periph_data_i(periph_data_i), .periph_ready_i(periph_ready_i),
    .timeout_o(timeout_o), .err_cnt_o(err_cnt_o)
  );
  int n_cmp = 0, n_fail = 0;
  bit chk_en = 1'b0;
  logic [8:0] exp_valid = '0;
  logic [4:0] exp_addr = '0;
  logic [31:0] exp_data = '0, exp_prdata = '0, last_prdata = '0;
  logic exp_rwn = 1'b0, exp_pready = 1'b0, exp_slverr = 1'b0, exp_tmo = 1'b0, last_slverr = 1'b0;
  int m_errcnt = 0, n_valid = 0, n_tmo = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    check("valid", 32'(periph_valid_o), 32'(exp_valid));
    check("pready", 32'(apb.PREADY), 32'(exp_pready));
    check("pslverr", 32'(apb.PSLVERR), 32'(exp_slverr));
    check("prdata", apb.PRDATA, exp_prdata);
    check("timeout", 32'(timeout_o), 32'(exp_tmo));
    check("err_cnt", 32'(err_cnt_o), 32'(m_errcnt));
    if (exp_valid != '0) begin
      check("paddr", 32'(periph_addr_o), 32'(exp_addr));
      check("pdata", periph_data_o, exp_data);
      check("rwn", 32'(periph_rwn_o), 32'(exp_rwn));
    end
    if (periph_valid_o != '0) n_valid++;
    if (timeout_o) n_tmo++;
    if (apb.PREADY) begin
      last_prdata = apb.PRDATA;
      last_slverr = apb.PSLVERR;
    end
    if (exp_pready && exp_slverr && m_errcnt < 255) m_errcnt++;
  end
  // lat = valid cycle (1-based) in which the slot acknowledges; 0 = never
  task automatic xfer(input logic [11:0] addr, input logic [31:0] wdata, input logic wr,
                      input int lat, input logic [31:0] pdata, input bit b2b);
    int id, nv;
    bit mapped, ok;
    logic [8:0] oh;
    id = int'(addr[11:7]);
    mapped = id < 9;
    ok = mapped && lat > 0 && lat <= TO;
    nv = mapped ? (ok ? lat : TO) : 0;
    oh = mapped ? 9'(1) << id : 9'h0;
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = addr; apb.PWDATA = wdata; apb.PWRITE = wr;
    periph_ready_i = '0;
    if (mapped) periph_data_i[id] = pdata;
    exp_valid = '0; exp_pready = 1'b0; exp_slverr = 1'b0; exp_prdata = '0; exp_tmo = 1'b0;
    for (int k = 1; k <= nv; k++) begin
      @(posedge clk); #1;
      apb.PENABLE = 1'b1;
      exp_valid = oh; exp_addr = addr[6:2]; exp_data = wdata; exp_rwn = !wr;
      exp_tmo = !ok && k == nv;
      periph_ready_i = (k == lat) ? oh : ~oh;
    end
    @(posedge clk); #1;
    apb.PENABLE = 1'b1; periph_ready_i = '0;
    exp_valid = '0; exp_tmo = 1'b0; exp_pready = 1'b1; exp_slverr = !ok;
    exp_prdata = (ok && !wr) ? pdata : 32'h0;
    if (!b2b) begin
      @(posedge clk); #1;
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
      exp_pready = 1'b0; exp_slverr = 1'b0; exp_prdata = '0;
    end
  endtask
  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0; apb.PWRITE = 1'b0;
    periph_ready_i = '0;
    for (int i = 0; i < 9; i++) periph_data_i[i] = 32'hDEAD_0000 + 32'(i);
    #12;
    check("rst_valid", 32'(periph_valid_o), 32'h0);
    check("rst_pready", 32'(apb.PREADY), 32'h0);
    check("rst_prdata", apb.PRDATA, 32'h0);
    check("rst_pdata", periph_data_o, 32'h0);
    check("rst_errcnt", 32'(err_cnt_o), 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1; chk_en = 1'b1;
    n_valid = 0;
    xfer(12'h188, 32'h0, 1'b0, 1, 32'hCAFE0003, 1'b0);
    check("t1_prdata", last_prdata, 32'hCAFE0003);
    check("t1_valid_cycles", 32'(n_valid), 32'd1);
    n_valid = 0;
    xfer(12'h004, 32'h1234, 1'b1, 5, 32'h5555_0000, 1'b0);
    check("t2_valid_cycles", 32'(n_valid), 32'd5);
    check("t2_prdata", last_prdata, 32'h0);
    check("t2_slverr", 32'(last_slverr), 32'h0);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = 12'h100; apb.PWRITE = 1'b0; apb.PWDATA = 32'h0;
    repeat (2) begin
      @(posedge clk); #1;
      apb.PENABLE = 1'b1;
      exp_valid = 9'h004; exp_addr = 5'd0; exp_data = 32'h0; exp_rwn = 1'b1;
    end
    #2;
    chk_en = 1'b0; rstn = 1'b0;
    #1;
    check("async_valid_clr", 32'(periph_valid_o), 32'h0);
    check("async_pready", 32'(apb.PREADY), 32'h0);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    exp_valid = '0; m_errcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1; chk_en = 1'b1;
    xfer(12'h104, 32'h0, 1'b0, 2, 32'hBEEF0002, 1'b0);
    check("post_rst_prdata", last_prdata, 32'hBEEF0002);
    n_valid = 0;
    xfer(12'hF00, 32'h77, 1'b1, 1, 32'h0, 1'b0);
    check("unmapped_valid", 32'(n_valid), 32'd0);
    check("unmapped_slverr", 32'(last_slverr), 32'h1);
    check("unmapped_errcnt", 32'(err_cnt_o), 32'd1);
    n_valid = 0; n_tmo = 0;
    xfer(12'h280, 32'h0, 1'b0, 0, 32'h12345678, 1'b0);
    check("tmo_valid_cycles", 32'(n_valid), 32'd16);
    check("tmo_pulses", 32'(n_tmo), 32'd1);
    check("tmo_slverr", 32'(last_slverr), 32'h1);
    check("tmo_prdata", last_prdata, 32'h0);
    n_valid = 0; n_tmo = 0;
    xfer(12'h300, 32'h0, 1'b0, TO, 32'hA5A5A5A5, 1'b0);
    check("edge_valid_cycles", 32'(n_valid), 32'd16);
    check("edge_pulses", 32'(n_tmo), 32'd0);
    check("edge_slverr", 32'(last_slverr), 32'h0);
    check("edge_prdata", last_prdata, 32'hA5A5A5A5);
    xfer(12'h408, 32'h0, 1'b0, 1, 32'h88880008, 1'b1);
    xfer(12'h38C, 32'h99, 1'b1, 2, 32'h0, 1'b1);
    xfer(12'hF80, 32'h0, 1'b0, 0, 32'h0, 1'b0);
    check("b2b_errcnt", 32'(err_cnt_o), 32'd3);
    for (int i = 0; i < 300; i++) xfer(12'hF00 | 12'(i & 8'hFF) >> 1, 32'h0, 1'b0, 0, 32'h0, 1'b0);
    check("sat_errcnt", 32'(err_cnt_o), 32'd255);
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
